rob_commit_unit: RTL and testbench

//  Reorder buffer serving the rename stage: takes up to 2 new entries/cycle, hands out tickets, sets done on writeback.

---
 rtl/rob_commit_if.sv | 85 ++++++++
 rtl/rob_commit_unit.sv | 257 +++++++++++++++++++++++++
 tb/tb_rob_commit_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// ---------------------------------------------------------------------------
// rob_commit_if
// Purpose: bundles the rename-side allocation port, the writeback port and
//          the in-order commit port of the reorder buffer.
//
// Handshake rules (one place, applies to every group below):
//   - req_valid_1/_2 are single-cycle requests with no ready. The producer
//     checks is_full_o / two_empty_o in the same cycle. A request that does
//     not fit is dropped whole; it is never half-accepted.
//   - wb_valid_i is a fire-and-forget strobe. It never back-pressures.
//   - commit_valid_o and flush_valid_o are registered strobes with no ready.
//     The consumer (free list / RAT) must accept them in the cycle they are
//     high. The commit_* payload is meaningful only while commit_valid_o=1.
//
// Signals:
//   req_*        allocation requests, slot 1 and slot 2      (master -> slave)
//   ticket_o     tail index handed to slot 1                 (slave -> master)
//   is_full_o    no free entry or draining                   (slave -> master)
//   two_empty_o  at least two free entries and running       (slave -> master)
//   wb_*         writeback completion                        (master -> slave)
//   commit_*     retire port                                 (slave -> master)
//   flush_valid_o one-cycle RAT restore pulse                (slave -> master)
//   dbg_draining_o FSM state: 1 while squashing young entries (slave -> master)
// ---------------------------------------------------------------------------
interface rob_commit_if #(
    parameter int ROB_ENTRIES  = 8,
    parameter int P_ADDR_WIDTH = 5,
    parameter int L_ADDR_WIDTH = 5,
    parameter int UOP_WIDTH    = 5
);
    localparam int ROB_INDEX_BITS = $clog2(ROB_ENTRIES);

    logic                      req_valid_1;
    logic                      req_valid_2;
    logic                      req_dest_1;
    logic                      req_dest_2;
    logic [L_ADDR_WIDTH-1:0]   req_lreg_1;
    logic [L_ADDR_WIDTH-1:0]   req_lreg_2;
    logic [P_ADDR_WIDTH-1:0]   req_preg_1;
    logic [P_ADDR_WIDTH-1:0]   req_preg_2;
    logic [P_ADDR_WIDTH-1:0]   req_ppreg_1;
    logic [P_ADDR_WIDTH-1:0]   req_ppreg_2;
    logic [UOP_WIDTH-1:0]      req_uop_1;
    logic [UOP_WIDTH-1:0]      req_uop_2;

    logic [ROB_INDEX_BITS-1:0] ticket_o;
    logic                      is_full_o;
    logic                      two_empty_o;

    logic                      wb_valid_i;
    logic [ROB_INDEX_BITS-1:0] wb_ticket_i;
    logic                      wb_mispred_i;

    logic                      commit_valid_o;
    logic [ROB_INDEX_BITS-1:0] commit_ticket_o;
    logic [L_ADDR_WIDTH-1:0]   commit_ldst_o;
    logic [P_ADDR_WIDTH-1:0]   commit_pdst_o;
    logic [P_ADDR_WIDTH-1:0]   commit_ppdst_o;
    logic [UOP_WIDTH-1:0]      commit_uop_o;
    logic                      commit_flushed_o;
    logic                      flush_valid_o;
    logic                      dbg_draining_o;

    modport master (
        output req_valid_1, req_valid_2, req_dest_1, req_dest_2,
               req_lreg_1, req_lreg_2, req_preg_1, req_preg_2,
               req_ppreg_1, req_ppreg_2, req_uop_1, req_uop_2,
               wb_valid_i, wb_ticket_i, wb_mispred_i,
        input  ticket_o, is_full_o, two_empty_o,
               commit_valid_o, commit_ticket_o, commit_ldst_o,
               commit_pdst_o, commit_ppdst_o, commit_uop_o,
               commit_flushed_o, flush_valid_o, dbg_draining_o
    );

    modport slave (
        input  req_valid_1, req_valid_2, req_dest_1, req_dest_2,
               req_lreg_1, req_lreg_2, req_preg_1, req_preg_2,
               req_ppreg_1, req_ppreg_2, req_uop_1, req_uop_2,
               wb_valid_i, wb_ticket_i, wb_mispred_i,
        output ticket_o, is_full_o, two_empty_o,
               commit_valid_o, commit_ticket_o, commit_ldst_o,
               commit_pdst_o, commit_ppdst_o, commit_uop_o,
               commit_flushed_o, flush_valid_o, dbg_draining_o
    );
endinterface

// File: rtl/rob_commit_unit.sv
// ---------------------------------------------------------------------------
// rob_commit_unit
// Purpose: reorder buffer between rename and the free list / RAT. Accepts up
//          to two entries per cycle at the tail, marks entries done on
//          writeback and retires one entry per cycle from the head. When a
//          mispredicted branch retires, a flush pulse is issued and every
//          younger entry is retired with commit_flushed_o=1 so its pdst can
//          be reclaimed without touching the RAT.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   bus (slave)         allocation, writeback and commit groups (rob_commit_if)
//   stat_commits_o      non-flushed retire count      (only with ROB_STATS_EN)
//   stat_flushes_o      flush pulse count             (only with ROB_STATS_EN)
//
// Build option: define ROB_STATS_EN to add the two 32-bit statistics
// counters and their ports. Without it the block behaves identically.
// ---------------------------------------------------------------------------
module rob_commit_unit #(
    parameter int ROB_ENTRIES  = 8,
    parameter int P_ADDR_WIDTH = 5,
    parameter int L_ADDR_WIDTH = 5,
    parameter int UOP_WIDTH    = 5
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ROB_STATS_EN
    output logic [31:0] stat_commits_o,
    output logic [31:0] stat_flushes_o,
`endif
    rob_commit_if.slave bus
);

    localparam int ROB_INDEX_BITS = $clog2(ROB_ENTRIES);
    localparam int IW             = ROB_INDEX_BITS;
    localparam int CW             = ROB_INDEX_BITS + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(ROB_ENTRIES);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Control state (asynchronously reset).
    state_e                  state_q, state_d;
    logic [IW-1:0]           head_q, head_d;
    logic [IW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic [ROB_ENTRIES-1:0]  valid_q, valid_d;
    logic [ROB_ENTRIES-1:0]  done_q, done_d;
    logic [ROB_ENTRIES-1:0]  mispred_q, mispred_d;

    // Registered commit port.
    logic                    commit_valid_q, commit_valid_d;
    logic [IW-1:0]           commit_ticket_q, commit_ticket_d;
    logic [L_ADDR_WIDTH-1:0] commit_ldst_q, commit_ldst_d;
    logic [P_ADDR_WIDTH-1:0] commit_pdst_q, commit_pdst_d;
    logic [P_ADDR_WIDTH-1:0] commit_ppdst_q, commit_ppdst_d;
    logic [UOP_WIDTH-1:0]    commit_uop_q, commit_uop_d;
    logic                    commit_flushed_q, commit_flushed_d;
    logic                    flush_valid_q, flush_valid_d;

    // Payload storage; only meaningful where valid_q is set, so no reset.
    logic [L_ADDR_WIDTH-1:0] ldst_q  [ROB_ENTRIES];
    logic [L_ADDR_WIDTH-1:0] ldst_d  [ROB_ENTRIES];
    logic [P_ADDR_WIDTH-1:0] pdst_q  [ROB_ENTRIES];
    logic [P_ADDR_WIDTH-1:0] pdst_d  [ROB_ENTRIES];
    logic [P_ADDR_WIDTH-1:0] ppdst_q [ROB_ENTRIES];
    logic [P_ADDR_WIDTH-1:0] ppdst_d [ROB_ENTRIES];
    logic [UOP_WIDTH-1:0]    uop_q   [ROB_ENTRIES];
    logic [UOP_WIDTH-1:0]    uop_d   [ROB_ENTRIES];

`ifdef ROB_STATS_EN
    logic [31:0]             stat_commits_q, stat_commits_d;
    logic [31:0]             stat_flushes_q, stat_flushes_d;
`endif

    // Combinational helpers.
    logic [CW-1:0]           free_cnt;
    logic [1:0]              n_req;
    logic                    alloc_1;
    logic                    alloc_2;
    logic [IW-1:0]           tail_p1;
    logic                    retire_run;
    logic                    retire_drain;
    logic                    retire;
    logic [CW-1:0]           n_alloc;

    always_comb begin
        free_cnt  = FULL_CNT - count_q;
        tail_p1   = tail_q + IW'(1);

        // Slot 2 is only meaningful alongside slot 1.
        n_req = 2'd0;
        if (bus.req_valid_1) begin
            n_req = bus.req_valid_2 ? 2'd2 : 2'd1;
        end

        // Space is judged on the pre-edge count: a commit in the same cycle
        // does not make room for this cycle's request.
        alloc_1 = (state_q == ST_RUN) && bus.req_valid_1 && (CW'(n_req) <= free_cnt);
        alloc_2 = alloc_1 && bus.req_valid_2;
        n_alloc = CW'(alloc_1) + CW'(alloc_2);

        // Retire decisions use pre-edge done bits, so a writeback to the head
        // in this cycle retires it one cycle later.
        retire_run   = (state_q == ST_RUN) && valid_q[head_q] && done_q[head_q];
        retire_drain = (state_q == ST_DRAIN) && (count_q != '0);
        retire       = retire_run || retire_drain;

        count_d = count_q + n_alloc - CW'(retire);
        tail_d  = tail_q + IW'(alloc_1) + IW'(alloc_2);
        head_d  = head_q + IW'(retire);

        valid_d   = valid_q;
        done_d    = done_q;
        mispred_d = mispred_q;
        ldst_d    = ldst_q;
        pdst_d    = pdst_q;
        ppdst_d   = ppdst_q;
        uop_d     = uop_q;

        // Writeback only lands on live entries and is ignored while draining.
        if ((state_q == ST_RUN) && bus.wb_valid_i && valid_q[bus.wb_ticket_i]) begin
            done_d[bus.wb_ticket_i]    = 1'b1;
            mispred_d[bus.wb_ticket_i] = mispred_q[bus.wb_ticket_i] | bus.wb_mispred_i;
        end

        if (alloc_1) begin
            valid_d[tail_q]   = 1'b1;
            done_d[tail_q]    = 1'b0;
            mispred_d[tail_q] = 1'b0;
            ldst_d[tail_q]    = bus.req_dest_1 ? bus.req_lreg_1 : '0;
            pdst_d[tail_q]    = bus.req_preg_1;
            ppdst_d[tail_q]   = bus.req_ppreg_1;
            uop_d[tail_q]     = bus.req_uop_1;
        end
        if (alloc_2) begin
            valid_d[tail_p1]   = 1'b1;
            done_d[tail_p1]    = 1'b0;
            mispred_d[tail_p1] = 1'b0;
            ldst_d[tail_p1]    = bus.req_dest_2 ? bus.req_lreg_2 : '0;
            pdst_d[tail_p1]    = bus.req_preg_2;
            ppdst_d[tail_p1]   = bus.req_ppreg_2;
            uop_d[tail_p1]     = bus.req_uop_2;
        end

        // The head can never coincide with an allocated slot: that would need
        // an empty ROB (no retire) or a full one (no alloc).
        if (retire) begin
            valid_d[head_q]   = 1'b0;
            done_d[head_q]    = 1'b0;
            mispred_d[head_q] = 1'b0;
        end

        commit_valid_d   = retire;
        commit_ticket_d  = retire ? head_q : '0;
        commit_ldst_d    = retire ? ldst_q[head_q] : '0;
        commit_pdst_d    = retire ? pdst_q[head_q] : '0;
        commit_ppdst_d   = retire ? ppdst_q[head_q] : '0;
        commit_uop_d     = retire ? uop_q[head_q] : '0;
        commit_flushed_d = retire_drain;
        flush_valid_d    = retire_run && mispred_q[head_q];

        // Drain only when something younger than the branch remains
        // (including entries allocated in the same cycle).
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (flush_valid_d && (count_d != '0)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (count_d == '0) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

`ifdef ROB_STATS_EN
        stat_commits_d = stat_commits_q + 32'(retire_run);
        stat_flushes_d = stat_flushes_q + 32'(flush_valid_d);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_RUN;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            valid_q          <= '0;
            done_q           <= '0;
            mispred_q        <= '0;
            commit_valid_q   <= 1'b0;
            commit_ticket_q  <= '0;
            commit_ldst_q    <= '0;
            commit_pdst_q    <= '0;
            commit_ppdst_q   <= '0;
            commit_uop_q     <= '0;
            commit_flushed_q <= 1'b0;
            flush_valid_q    <= 1'b0;
`ifdef ROB_STATS_EN
            stat_commits_q   <= '0;
            stat_flushes_q   <= '0;
`endif
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            valid_q          <= valid_d;
            done_q           <= done_d;
            mispred_q        <= mispred_d;
            commit_valid_q   <= commit_valid_d;
            commit_ticket_q  <= commit_ticket_d;
            commit_ldst_q    <= commit_ldst_d;
            commit_pdst_q    <= commit_pdst_d;
            commit_ppdst_q   <= commit_ppdst_d;
            commit_uop_q     <= commit_uop_d;
            commit_flushed_q <= commit_flushed_d;
            flush_valid_q    <= flush_valid_d;
`ifdef ROB_STATS_EN
            stat_commits_q   <= stat_commits_d;
            stat_flushes_q   <= stat_flushes_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        ldst_q  <= ldst_d;
        pdst_q  <= pdst_d;
        ppdst_q <= ppdst_d;
        uop_q   <= uop_d;
    end

    assign bus.ticket_o         = tail_q;
    assign bus.is_full_o        = (count_q == FULL_CNT) || (state_q == ST_DRAIN);
    assign bus.two_empty_o      = (free_cnt >= CW'(2)) && (state_q == ST_RUN);
    assign bus.commit_valid_o   = commit_valid_q;
    assign bus.commit_ticket_o  = commit_ticket_q;
    assign bus.commit_ldst_o    = commit_ldst_q;
    assign bus.commit_pdst_o    = commit_pdst_q;
    assign bus.commit_ppdst_o   = commit_ppdst_q;
    assign bus.commit_uop_o     = commit_uop_q;
    assign bus.commit_flushed_o = commit_flushed_q;
    assign bus.flush_valid_o    = flush_valid_q;
    assign bus.dbg_draining_o   = (state_q == ST_DRAIN);

`ifdef ROB_STATS_EN
    assign stat_commits_o = stat_commits_q;
    assign stat_flushes_o = stat_flushes_q;
`endif

endmodule

// File: tb/tb_rob_commit_unit.sv
module tb_rob_commit_unit;

    localparam int N   = 8;
    localparam int IW  = 3;
    localparam int PW  = 5;
    localparam int LW  = 5;
    localparam int UW  = 5;

    logic clk;
    logic rst;

    rob_commit_if #(.ROB_ENTRIES(N), .P_ADDR_WIDTH(PW), .L_ADDR_WIDTH(LW), .UOP_WIDTH(UW)) bus ();

`ifdef ROB_STATS_EN
    logic [31:0] stat_commits;
    logic [31:0] stat_flushes;
`endif

    rob_commit_unit #(
        .ROB_ENTRIES(N), .P_ADDR_WIDTH(PW), .L_ADDR_WIDTH(LW), .UOP_WIDTH(UW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef ROB_STATS_EN
        .stat_commits_o (stat_commits),
        .stat_flushes_o (stat_flushes),
`endif
        .bus            (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        int           tkt;
        logic [LW-1:0] ldst;
        logic [PW-1:0] pdst;
        logic [PW-1:0] ppdst;
        bit           done;
        bit           mis;
    } ent_t;

    ent_t mq[$];        // in-flight entries, oldest first
    int   next_ticket;
    bit   m_drain;
    int   m_commits;
    int   m_flushes;

    bit            exp_cv, exp_fv, exp_fl;
    int            exp_ct;
    logic [LW-1:0] exp_ldst;
    logic [PW-1:0] exp_pdst, exp_ppdst;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        next_ticket = 0;
        m_drain     = 0;
        m_commits   = 0;
        m_flushes   = 0;
        exp_cv      = 0;
        exp_fv      = 0;
        exp_fl      = 0;
        exp_ct      = 0;
        exp_ldst    = '0;
        exp_pdst    = '0;
        exp_ppdst   = '0;
    endtask

    // One clock of the reference model, using the inputs currently driven.
    task automatic model_step();
        bit   ret;
        bit   fl;
        bit   flsh;
        int   n;
        ent_t e;
        ent_t ne;
        ret  = 0;
        fl   = 0;
        flsh = 0;
        if (!m_drain) begin
            if (mq.size() > 0 && mq[0].done) begin
                ret  = 1;
                flsh = mq[0].mis;
            end
        end else if (mq.size() > 0) begin
            ret = 1;
            fl  = 1;
        end
        if (ret) e = mq[0];

        if (!m_drain && bus.wb_valid_i) begin
            foreach (mq[i]) begin
                if (mq[i].tkt == int'(bus.wb_ticket_i)) begin
                    mq[i].done = 1;
                    mq[i].mis  = mq[i].mis | bus.wb_mispred_i;
                end
            end
        end

        n = bus.req_valid_1 ? (bus.req_valid_2 ? 2 : 1) : 0;
        if (!m_drain && n > 0 && (N - mq.size()) >= n) begin
            ne.tkt   = next_ticket;
            ne.ldst  = bus.req_dest_1 ? bus.req_lreg_1 : '0;
            ne.pdst  = bus.req_preg_1;
            ne.ppdst = bus.req_ppreg_1;
            ne.done  = 0;
            ne.mis   = 0;
            mq.push_back(ne);
            if (n == 2) begin
                ne.tkt   = (next_ticket + 1) % N;
                ne.ldst  = bus.req_dest_2 ? bus.req_lreg_2 : '0;
                ne.pdst  = bus.req_preg_2;
                ne.ppdst = bus.req_ppreg_2;
                mq.push_back(ne);
            end
            next_ticket = (next_ticket + n) % N;
        end

        if (ret) void'(mq.pop_front());
        if (ret && flsh) m_drain = (mq.size() > 0);
        else if (m_drain && mq.size() == 0) m_drain = 0;

        exp_cv = ret;
        exp_fv = flsh;
        exp_fl = fl;
        if (ret) begin
            exp_ct    = e.tkt;
            exp_ldst  = e.ldst;
            exp_pdst  = e.pdst;
            exp_ppdst = e.ppdst;
        end
        if (ret && !fl) m_commits++;
        if (flsh) m_flushes++;
    endtask

    task automatic chk_all();
        chk("commit_valid", 32'(bus.commit_valid_o), 32'(exp_cv));
        chk("flush_valid", 32'(bus.flush_valid_o), 32'(exp_fv));
        if (exp_cv) begin
            chk("commit_ticket", 32'(bus.commit_ticket_o), 32'(exp_ct));
            chk("commit_ldst", 32'(bus.commit_ldst_o), 32'(exp_ldst));
            chk("commit_pdst", 32'(bus.commit_pdst_o), 32'(exp_pdst));
            chk("commit_ppdst", 32'(bus.commit_ppdst_o), 32'(exp_ppdst));
            chk("commit_flushed", 32'(bus.commit_flushed_o), 32'(exp_fl));
        end
        chk("ticket_o", 32'(bus.ticket_o), 32'(next_ticket));
        chk("is_full", 32'(bus.is_full_o), 32'((mq.size() == N) || m_drain));
        chk("two_empty", 32'(bus.two_empty_o), 32'(((N - mq.size()) >= 2) && !m_drain));
        chk("draining", 32'(bus.dbg_draining_o), 32'(m_drain));
`ifdef ROB_STATS_EN
        chk("stat_commits", stat_commits, 32'(m_commits));
        chk("stat_flushes", stat_flushes, 32'(m_flushes));
`endif
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.req_valid_1  = 0; bus.req_valid_2 = 0;
        bus.req_dest_1   = 0; bus.req_dest_2  = 0;
        bus.req_lreg_1   = '0; bus.req_lreg_2  = '0;
        bus.req_preg_1   = '0; bus.req_preg_2  = '0;
        bus.req_ppreg_1  = '0; bus.req_ppreg_2 = '0;
        bus.req_uop_1    = '0; bus.req_uop_2   = '0;
        bus.wb_valid_i   = 0;
        bus.wb_ticket_i  = '0;
        bus.wb_mispred_i = 0;
    endtask

    task automatic set_alloc1(input logic d, input logic [LW-1:0] l, input logic [PW-1:0] p, input logic [PW-1:0] pp);
        bus.req_valid_1 = 1; bus.req_dest_1 = d;
        bus.req_lreg_1  = l; bus.req_preg_1 = p; bus.req_ppreg_1 = pp;
        bus.req_uop_1   = UW'($urandom_range(0, 31));
    endtask

    task automatic set_alloc2(input logic d, input logic [LW-1:0] l, input logic [PW-1:0] p, input logic [PW-1:0] pp);
        bus.req_valid_2 = 1; bus.req_dest_2 = d;
        bus.req_lreg_2  = l; bus.req_preg_2 = p; bus.req_ppreg_2 = pp;
        bus.req_uop_2   = UW'($urandom_range(0, 31));
    endtask

    task automatic set_rand_alloc(input int n);
        if (n >= 1) set_alloc1(1'($urandom_range(0, 1)), LW'($urandom_range(0, 31)),
                               PW'($urandom_range(0, 31)), PW'($urandom_range(0, 31)));
        if (n >= 2) set_alloc2(1'($urandom_range(0, 1)), LW'($urandom_range(0, 31)),
                               PW'($urandom_range(0, 31)), PW'($urandom_range(0, 31)));
    endtask

    task automatic set_wb(input int t, input logic m);
        bus.wb_valid_i   = 1;
        bus.wb_ticket_i  = IW'(t);
        bus.wb_mispred_i = m;
    endtask

    // Advance one clock: update model from driven inputs, check after edge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk_all();
        set_idle();
    endtask

    task automatic do_reset();
        rst = 1;
        set_idle();
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        chk_all();
    endtask

    // Complete every outstanding entry and let the ROB empty out.
    task automatic drain_all();
        ent_t snap[$];
        snap = mq;
        foreach (snap[i]) begin
            set_wb(snap[i].tkt, 1'b0);
            cycle();
        end
        for (int k = 0; k < 4 * N && mq.size() > 0; k++) cycle();
        chk("drain_empty", 32'(mq.size()), 32'd0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst = 1;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset values.
        chk("rst_ticket", 32'(bus.ticket_o), 32'd0);
        chk("rst_full", 32'(bus.is_full_o), 32'd0);
        chk("rst_two_empty", 32'(bus.two_empty_o), 32'd1);
        chk("rst_commit_valid", 32'(bus.commit_valid_o), 32'd0);
        chk("rst_flush_valid", 32'(bus.flush_valid_o), 32'd0);
        rst = 0;

        // Dual alloc, out-of-order writeback, in-order commit.
        set_alloc1(1, 5'd9, 5'd17, 5'd9);
        set_alloc2(1, 5'd10, 5'd18, 5'd10);
        cycle();
        set_wb(1, 0); cycle();
        set_wb(0, 0); cycle();
        cycle();
        chk("s2_c0_valid", 32'(bus.commit_valid_o), 32'd1);
        chk("s2_c0_ticket", 32'(bus.commit_ticket_o), 32'd0);
        chk("s2_c0_ldst", 32'(bus.commit_ldst_o), 32'd9);
        chk("s2_c0_pdst", 32'(bus.commit_pdst_o), 32'd17);
        chk("s2_c0_ppdst", 32'(bus.commit_ppdst_o), 32'd9);
        chk("s2_c0_flushed", 32'(bus.commit_flushed_o), 32'd0);
        cycle();
        chk("s2_c1_ticket", 32'(bus.commit_ticket_o), 32'd1);
        chk("s2_c1_ldst", 32'(bus.commit_ldst_o), 32'd10);
        chk("s2_c1_pdst", 32'(bus.commit_pdst_o), 32'd18);
        cycle();
        chk("s2_idle_valid", 32'(bus.commit_valid_o), 32'd0);

        // Fill, drop on full, free one, wrap.
        do_reset();
        for (int i = 0; i < N / 2; i++) begin
            set_rand_alloc(2);
            cycle();
        end
        chk("s3_full", 32'(bus.is_full_o), 32'd1);
        chk("s3_two_empty", 32'(bus.two_empty_o), 32'd0);
        chk("s3_ticket_wrap", 32'(bus.ticket_o), 32'd0);
        set_rand_alloc(1);
        cycle();
        chk("s3_drop_ticket", 32'(bus.ticket_o), 32'd0);
        set_wb(0, 0);
        set_rand_alloc(1);   // still refused: full pre-edge
        cycle();
        set_rand_alloc(1);   // commit edge: full pre-edge, refused
        cycle();
        chk("s3_commit_t0", 32'(bus.commit_ticket_o), 32'd0);
        chk("s3_not_full", 32'(bus.is_full_o), 32'd0);
        set_rand_alloc(1);
        cycle();
        chk("s3_resume_ticket", 32'(bus.ticket_o), 32'd1);
        chk("s3_full_again", 32'(bus.is_full_o), 32'd1);
        drain_all();

        // Mispredict at head: flush then squash t1..t4.
        do_reset();
        set_alloc1(1, 5'd1, 5'd20, 5'd1); set_alloc2(1, 5'd2, 5'd21, 5'd2); cycle();
        set_alloc1(1, 5'd3, 5'd22, 5'd3); set_alloc2(0, 5'd4, 5'd23, 5'd4); cycle();
        set_alloc1(1, 5'd5, 5'd24, 5'd5); cycle();
        set_wb(0, 1); cycle();
        cycle();
        chk("s4_flush_pulse", 32'(bus.flush_valid_o), 32'd1);
        chk("s4_t0_flushed", 32'(bus.commit_flushed_o), 32'd0);
        chk("s4_t0_ticket", 32'(bus.commit_ticket_o), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            cycle();
            chk("s4_sq_flushed", 32'(bus.commit_flushed_o), 32'd1);
            chk("s4_sq_pdst", 32'(bus.commit_pdst_o), 32'(20 + i));
            chk("s4_sq_no_flush", 32'(bus.flush_valid_o), 32'd0);
        end
        chk("s4_ticket_5", 32'(bus.ticket_o), 32'd5);
        chk("s4_run", 32'(bus.dbg_draining_o), 32'd0);
`ifdef ROB_STATS_EN
        chk("s6_stat_commits", stat_commits, 32'd1);
        chk("s6_stat_flushes", stat_flushes, 32'd1);
`endif
        cycle();
        chk("s4_quiet", 32'(bus.commit_valid_o), 32'd0);

        // Reset while draining.
        do_reset();
        set_rand_alloc(2); cycle();
        set_rand_alloc(2); cycle();
        set_wb(0, 1); cycle();
        cycle();
        cycle();
        chk("s5_draining", 32'(bus.dbg_draining_o), 32'd1);
        rst = 1;
        #2;
        chk("s5_async_cv", 32'(bus.commit_valid_o), 32'd0);
        chk("s5_async_fl", 32'(bus.commit_flushed_o), 32'd0);
        chk("s5_async_ticket", 32'(bus.ticket_o), 32'd0);
        chk("s5_async_full", 32'(bus.is_full_o), 32'd0);
        chk("s5_async_two", 32'(bus.two_empty_o), 32'd1);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("s5_no_commit", 32'(bus.commit_valid_o), 32'd0);
        end

        // Random traffic against the model.
        do_reset();
        repeat (1500) begin
            if ($urandom_range(0, 3) != 0) set_rand_alloc($urandom_range(1, 2));
            if ($urandom_range(0, 9) < 7) begin
                if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                    set_wb(mq[$urandom_range(0, mq.size() - 1)].tkt, 1'($urandom_range(0, 15) == 0));
                else
                    set_wb($urandom_range(0, N - 1), 1'($urandom_range(0, 15) == 0));
            end
            cycle();
        end
        drain_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
